// File: rtl/fpnew_pkg.sv
// Shared FPnew types and limits used by the issue reorder buffer.
package fpnew_pkg;

    localparam int unsigned ROB_MAX_DEPTH = 32;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_issue_rob.sv
// In-order retire buffer for out-of-order opgroup results, indexed by issue tag.
// Optional same-cycle result forwarding to the retire port: define FPNEW_ROB_BYPASS_EN.
module fpnew_issue_rob
    import fpnew_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4,
    localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    output logic [IdxWidth-1:0] issue_tag_o,
    input  logic                res_valid_i,
    output logic                res_ready_o,
    input  logic [IdxWidth-1:0] res_tag_i,
    input  logic [Width-1:0]    res_result_i,
    input  status_t             res_status_i,
    input  logic                res_ext_bit_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    out_result_o,
    output status_t             out_status_o,
    output logic                out_ext_bit_o,
    output logic                busy_o
);

    localparam logic [IdxWidth:0] PtrOne = 1;

    logic [IdxWidth:0]   head_q, tail_q;
    logic [Depth-1:0]    done_q;
    logic [Width-1:0]    result_q [Depth];
    status_t             status_q [Depth];
    logic [Depth-1:0]    ext_q;

    logic [IdxWidth-1:0] head_idx, tail_idx, res_offset;
    logic [IdxWidth:0]   count;
    logic                empty, full, res_alloc;
    logic                issue_fire, res_write, set_done, out_fire, bypass_hit;

    assign head_idx = head_q[IdxWidth-1:0];
    assign tail_idx = tail_q[IdxWidth-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IdxWidth] != tail_q[IdxWidth]);
    assign count    = tail_q - head_q;

    // A tag is live when its distance from head lies inside the occupied window.
    assign res_offset = res_tag_i - head_idx;
    assign res_alloc  = ({1'b0, res_offset} < count);

    assign issue_ready_o = !full && !flush_i;
    assign issue_tag_o   = tail_idx;
    assign res_ready_o   = !flush_i;
    assign busy_o        = !empty;

    assign issue_fire = issue_valid_i && issue_ready_o;
    // Completed entries are frozen so a held retire payload cannot change.
    assign res_write  = res_valid_i && res_ready_o && res_alloc && !done_q[res_tag_i];
    assign out_fire   = out_valid_o && out_ready_i;
    assign set_done   = res_write && !(bypass_hit && out_ready_i);

`ifdef FPNEW_ROB_BYPASS_EN
    assign bypass_hit = res_valid_i && (res_tag_i == head_idx) && !empty &&
                        !done_q[head_idx] && !flush_i;

    always_comb begin
        out_valid_o   = (!empty && done_q[head_idx] && !flush_i) || bypass_hit;
        out_result_o  = result_q[head_idx];
        out_status_o  = status_q[head_idx];
        out_ext_bit_o = ext_q[head_idx];
        if (bypass_hit) begin
            out_result_o  = res_result_i;
            out_status_o  = res_status_i;
            out_ext_bit_o = res_ext_bit_i;
        end
    end
`else
    assign bypass_hit    = 1'b0;
    assign out_valid_o   = !empty && done_q[head_idx] && !flush_i;
    assign out_result_o  = result_q[head_idx];
    assign out_status_o  = status_q[head_idx];
    assign out_ext_bit_o = ext_q[head_idx];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            done_q <= '0;
        end else if (flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            done_q <= '0;
        end else begin
            if (out_fire) begin
                done_q[head_idx] <= 1'b0;
                head_q           <= head_q + PtrOne;
            end
            if (issue_fire) begin
                done_q[tail_idx] <= 1'b0;
                tail_q           <= tail_q + PtrOne;
            end
            if (set_done) begin
                done_q[res_tag_i] <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; done bits alone qualify it.
    always_ff @(posedge clk_i) begin
        if (res_write) begin
            result_q[res_tag_i] <= res_result_i;
            status_q[res_tag_i] <= res_status_i;
            ext_q[res_tag_i]    <= res_ext_bit_i;
        end
    end

endmodule

// File: tb/tb_fpnew_issue_rob.sv
// Randomized and scenario bench for fpnew_issue_rob against a queue-based reference model.
module tb_fpnew_issue_rob;
    import fpnew_pkg::*;

    localparam int Width = 32;
    localparam int Depth = 4;
    localparam int IdxW  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [IdxW-1:0] issue_tag;
    logic            res_valid = 1'b0;
    logic            res_ready;
    logic [IdxW-1:0] res_tag = '0;
    logic [31:0]     res_result = '0;
    logic [4:0]      res_status = '0;
    logic            res_ext = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_result;
    status_t         out_status;
    logic            out_ext;
    logic            busy;

    always #5 clk = ~clk;

    fpnew_issue_rob #(.Width(Width), .Depth(Depth)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .issue_valid_i(issue_valid),
        .issue_ready_o(issue_ready),
        .issue_tag_o  (issue_tag),
        .res_valid_i  (res_valid),
        .res_ready_o  (res_ready),
        .res_tag_i    (res_tag),
        .res_result_i (res_result),
        .res_status_i (res_status),
        .res_ext_bit_i(res_ext),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_result_o (out_result),
        .out_status_o (out_status),
        .out_ext_bit_o(out_ext),
        .busy_o       (busy)
    );

    // Reference model: ordered list of in-flight operations, oldest first.
    typedef struct {
        int         tag;
        bit         done;
        logic [31:0] res;
        logic [4:0]  st;
        logic        ext;
    } ent_t;

    ent_t q[$];
    int   next_tag = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit iv, input bit rv, input int rtag, input logic [31:0] rres,
                        input logic [4:0] rstat, input bit rext, input bit ordy, input bit fl);
        bit   e_full, e_ovld, hit, retire;
        ent_t e;
        @(negedge clk);
        issue_valid = iv;
        res_valid   = rv;
        res_tag     = rtag[IdxW-1:0];
        res_result  = rres;
        res_status  = rstat;
        res_ext     = rext;
        out_ready   = ordy;
        flush       = fl;
        #1;
        e_full = (q.size() == Depth);
        hit    = 1'b0;
`ifdef FPNEW_ROB_BYPASS_EN
        hit = rv && !fl && q.size() > 0 && q[0].tag == rtag && !q[0].done;
`endif
        e_ovld = !fl && ((q.size() > 0 && q[0].done) || hit);
        check_val("issue_ready", issue_ready, !e_full && !fl);
        check_val("issue_tag", issue_tag, next_tag);
        check_val("res_ready", res_ready, !fl);
        check_val("out_valid", out_valid, e_ovld);
        check_val("busy", busy, q.size() > 0);
        if (e_ovld) begin
            if (hit)
                check_val("out_payload", {out_result, out_status, out_ext}, {rres, rstat, rext});
            else
                check_val("out_payload", {out_result, out_status, out_ext},
                          {q[0].res, q[0].st, q[0].ext});
        end
        if (fl) begin
            q.delete();
            next_tag = 0;
        end else begin
            retire = e_ovld && ordy;
            if (rv && !(hit && retire)) begin
                foreach (q[i]) begin
                    if (q[i].tag == rtag && !q[i].done) begin
                        q[i].done = 1'b1;
                        q[i].res  = rres;
                        q[i].st   = rstat;
                        q[i].ext  = rext;
                    end
                end
            end
            if (retire) void'(q.pop_front());
            if (iv && !e_full) begin
                e.tag  = next_tag;
                e.done = 1'b0;
                e.res  = '0;
                e.st   = '0;
                e.ext  = 1'b0;
                q.push_back(e);
                next_tag = (next_tag + 1) % Depth;
            end
        end
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 32'h0, 5'h0, 0, ordy, 0);
    endtask

    task automatic issue1();
        step(1, 0, 0, 32'h0, 5'h0, 0, 0, 0);
    endtask

    task automatic result(input int t, input logic [31:0] v, input bit ordy);
        step(0, 1, t, v, v[4:0], v[5], ordy, 0);
    endtask

    initial begin
        int rtag;
        #2;
        check_val("rst_issue_ready", issue_ready, 1'b1);
        check_val("rst_issue_tag", issue_tag, 0);
        check_val("rst_res_ready", res_ready, 1'b1);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to capacity, then one result becomes visible a cycle later.
        for (int i = 0; i < 4; i++) issue1();
        idle(0);
        check_val("full_issue_ready", issue_ready, 1'b0);
        result(0, 32'h3F800000, 0);
        idle(0);
        check_val("first_result", out_result, 32'h3F800000);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // Out-of-order return, in-order retire.
        for (int i = 0; i < 3; i++) issue1();
        result(2, 32'hC0000022, 1);
        result(1, 32'h40400011, 1);
        result(0, 32'h3F000000, 1);
        for (int i = 0; i < 4; i++) idle(1);

        // Wrap-around with back-to-back issue and retire.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            step(1, i > 0, (i + 3) % 4, 32'h1000 + i, 5'(i), i[0], 1, 0);
        for (int i = 0; i < 3; i++) idle(1);

        // Full buffer: retire and issue attempt in the same cycle.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) issue1();
        result(0, 32'h0000ABCD, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check_val("full_reissue_tag_busy", busy, 1'b1);

        // Flush with three in flight; late result is dropped.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) issue1();
        step(0, 1, 1, 32'h11111111, 5'h1, 1, 1, 1);
        idle(1);
        check_val("flush_busy", busy, 1'b0);
        step(1, 1, 1, 32'h22222222, 5'h2, 0, 1, 0);
        idle(1);
        check_val("after_flush_out_valid", out_valid, 1'b0);

        // Result for the empty head, retired immediately when ready.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        issue1();
        result(0, 32'h5A5A5A5A, 1);
        idle(1);
        idle(1);

        // Asynchronous reset with entries in flight.
        issue1();
        issue1();
        result(0, 32'h77, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_busy", busy, 1'b0);
        check_val("midrst_out_valid", out_valid, 1'b0);
        check_val("midrst_issue_tag", issue_tag, 0);
        q.delete();
        next_tag = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            if (q.size() > 0 && $urandom_range(0, 9) < 7)
                rtag = q[$urandom_range(0, q.size() - 1)].tag;
            else
                rtag = $urandom_range(0, Depth - 1);
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, rtag, $urandom,
                 5'($urandom), 1'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
